// File: rtl/pipe_skid_stage.sv
// Two-entry skid buffer between pipeline stages. It has a registered in_ready and
// flush squash, plus an independently loaded side field for condition codes.
module pipe_skid_stage #(
  parameter int DATA_W = 128,
  parameter int SIDE_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              side_load,
  input  logic [SIDE_W-1:0] side_in,
  output logic [SIDE_W-1:0] side_out,
  input  logic              flush,
  output logic [1:0]        occupancy,
  output logic [1:0]        state_dbg
);

  // Handshake: a beat transfers on a rising edge where valid && ready are both high.
  // A source holds valid and data until that edge. in_ready never looks at out_ready.

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HALF  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   head_q, head_d;
  logic [DATA_W-1:0]   skid_q, skid_d;
  logic [SIDE_W-1:0]   side_q, side_d;
  logic                in_ready_q;
  logic [1:0]          occ_q;
  logic                head_vld;
  logic                accept;
  logic                consume;

  assign head_vld = (state_q != ST_EMPTY);
  assign accept   = in_valid && in_ready_q;
  assign consume  = head_vld && out_ready;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
      occ_q      <= 2'd0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_FULL);
      occ_q      <= state_d;
    end
  end

  // Next-state and datapath select
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (flush) begin
      // Any same-cycle accept is squashed; a consume still counts as delivered.
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            head_d  = in_data;
            state_d = ST_HALF;
          end
        end
        ST_HALF: begin
          if (accept && consume) begin
            head_d  = in_data;
          end else if (accept) begin
            skid_d  = in_data;
            state_d = ST_FULL;
          end else if (consume) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (consume) begin
            head_d  = skid_q;
            state_d = ST_HALF;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Side field loads whenever asked, regardless of handshake or flush.
  always_comb begin
    side_d = side_q;
    if (side_load) side_d = side_in;
  end

  // Data registers keep their contents when their entry goes invalid.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q <= '0;
      skid_q <= '0;
      side_q <= '0;
    end else begin
      head_q <= head_d;
      skid_q <= skid_d;
      side_q <= side_d;
    end
  end

  // Outputs
  always_comb begin
    out_valid = head_vld;
    out_data  = head_q;
    in_ready  = in_ready_q;
    occupancy = occ_q;
    side_out  = side_q;
    state_dbg = state_q;
  end

`ifndef SYNTHESIS
  a_no_ready_when_full: assert property (@(posedge clk) disable iff (reset)
    !(in_ready && occupancy == 2'd2));
  a_legal_state: assert property (@(posedge clk) disable iff (reset)
    state_q != 2'd3);
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: directed vector table, a hand-written streaming burst,
// and a long random run scored against a queue model of the buffer.
module tb_pipe_skid_stage;

  localparam int DW = 32;
  localparam int SW = 3;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          side_load;
  logic [SW-1:0] side_in;
  logic [SW-1:0] side_out;
  logic          flush;
  logic [1:0]    occupancy;
  logic [1:0]    state_dbg;

  int n_vec = 0;
  int n_mis = 0;

  pipe_skid_stage #(.DATA_W(DW), .SIDE_W(SW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .side_load (side_load),
    .side_in   (side_in),
    .side_out  (side_out),
    .flush     (flush),
    .occupancy (occupancy),
    .state_dbg (state_dbg)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    n_mis++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  typedef struct {
    logic          rst;
    logic          iv;
    logic [DW-1:0] din;
    logic          ordy;
    logic          fl;
    logic          sl;
    logic [SW-1:0] sin;
    logic          ov;
    logic [DW-1:0] od;
    logic          ir;
    logic [1:0]    occ;
    logic [SW-1:0] side;
  } vec_t;

  vec_t vecs[22];

  // Scoreboard: buffered payloads in acceptance order
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] last_head;
  logic [SW-1:0] side_m;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic iv, input logic [DW-1:0] din,
                       input logic ordy, input logic fl, input logic sl, input logic [SW-1:0] sin);
    reset     = rst;
    in_valid  = iv;
    in_data   = din;
    out_ready = ordy;
    flush     = fl;
    side_load = sl;
    side_in   = sin;
  endtask

  task automatic check_outputs(input string tag, input logic ov, input logic [DW-1:0] od,
                               input logic ir, input logic [1:0] occ, input logic [SW-1:0] side);
    check({tag, ".out_valid"}, DW'(out_valid), DW'(ov));
    check({tag, ".out_data"},  out_data,       od);
    check({tag, ".in_ready"},  DW'(in_ready),  DW'(ir));
    check({tag, ".occupancy"}, DW'(occupancy), DW'(occ));
    check({tag, ".side_out"},  DW'(side_out),  DW'(side));
  endtask

  // One random-phase cycle: model the edge from the queue, then compare.
  task automatic model_cycle();
    bit acc;
    bit con;
    acc = in_valid && (exp_q.size() < 2);
    con = (exp_q.size() > 0) && out_ready;
    @(posedge clk);
    #1;
    if (reset) begin
      exp_q.delete();
      last_head = '0;
      side_m    = '0;
    end else begin
      if (con) void'(exp_q.pop_front());
      if (flush) exp_q.delete();
      else if (acc) exp_q.push_back(in_data);
      if (side_load) side_m = side_in;
      if (exp_q.size() > 0) last_head = exp_q[0];
    end
    check_outputs("rand", exp_q.size() > 0, last_head, exp_q.size() < 2,
                  2'(exp_q.size()), side_m);
    check("rand.ready_when_full", DW'(in_ready && occupancy == 2'd2), '0);
  endtask

  initial begin
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);

    //          rst iv din        ordy fl sl sin      ov od         ir occ side
    vecs[0]  = '{1, 0, 32'h0,     0,   0, 0, 3'd0,   0, 32'h0,     1, 0, 3'd0};
    vecs[1]  = '{0, 1, 32'hA,     1,   0, 0, 3'd0,   1, 32'hA,     1, 1, 3'd0};
    vecs[2]  = '{0, 0, 32'h0,     1,   0, 0, 3'd0,   0, 32'hA,     1, 0, 3'd0};
    vecs[3]  = '{0, 1, 32'h1,     0,   0, 0, 3'd0,   1, 32'h1,     1, 1, 3'd0};
    vecs[4]  = '{0, 1, 32'h2,     0,   0, 0, 3'd0,   1, 32'h1,     0, 2, 3'd0};
    vecs[5]  = '{0, 1, 32'h3,     0,   0, 0, 3'd0,   1, 32'h1,     0, 2, 3'd0};
    vecs[6]  = '{0, 1, 32'h3,     1,   0, 0, 3'd0,   1, 32'h2,     1, 1, 3'd0};
    vecs[7]  = '{0, 1, 32'h3,     1,   0, 0, 3'd0,   1, 32'h3,     1, 1, 3'd0};
    vecs[8]  = '{0, 0, 32'h0,     1,   0, 0, 3'd0,   0, 32'h3,     1, 0, 3'd0};
    vecs[9]  = '{0, 1, 32'h5,     0,   0, 0, 3'd0,   1, 32'h5,     1, 1, 3'd0};
    vecs[10] = '{0, 1, 32'h6,     1,   0, 0, 3'd0,   1, 32'h6,     1, 1, 3'd0};
    vecs[11] = '{0, 1, 32'h7,     0,   0, 0, 3'd0,   1, 32'h6,     0, 2, 3'd0};
    vecs[12] = '{0, 1, 32'h8,     0,   0, 1, 3'b100, 1, 32'h6,     0, 2, 3'b100};
    vecs[13] = '{0, 1, 32'h8,     0,   0, 1, 3'b010, 1, 32'h6,     0, 2, 3'b010};
    vecs[14] = '{0, 1, 32'h9,     0,   1, 1, 3'b100, 0, 32'h6,     1, 0, 3'b100};
    vecs[15] = '{0, 0, 32'h0,     1,   0, 0, 3'd0,   0, 32'h6,     1, 0, 3'b100};
    vecs[16] = '{0, 1, 32'hB,     0,   0, 0, 3'd0,   1, 32'hB,     1, 1, 3'b100};
    vecs[17] = '{0, 1, 32'hF,     1,   1, 0, 3'd0,   0, 32'hB,     1, 0, 3'b100};
    vecs[18] = '{0, 1, 32'hC,     0,   0, 0, 3'd0,   1, 32'hC,     1, 1, 3'b100};
    vecs[19] = '{0, 1, 32'hD,     0,   0, 0, 3'd0,   1, 32'hC,     0, 2, 3'b100};
    vecs[20] = '{1, 1, 32'hE,     1,   0, 1, 3'd7,   0, 32'h0,     1, 0, 3'd0};
    vecs[21] = '{0, 0, 32'h0,     1,   0, 0, 3'd0,   0, 32'h0,     1, 0, 3'd0};

    @(posedge clk);
    #1;
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].iv, vecs[i].din, vecs[i].ordy, vecs[i].fl,
            vecs[i].sl, vecs[i].sin);
      @(posedge clk);
      #1;
      check_outputs($sformatf("vec%0d", i), vecs[i].ov, vecs[i].od, vecs[i].ir,
                    vecs[i].occ, vecs[i].side);
    end

    // Streaming burst: one payload per cycle with downstream always ready
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b1, 32'h100 + DW'(k), 1'b1, 1'b0, 1'b0, '0);
      @(posedge clk);
      #1;
      check_outputs($sformatf("stream%0d", k), 1'b1, 32'h100 + DW'(k), 1'b1, 2'd1, 3'd0);
    end
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
    @(posedge clk);
    #1;
    check_outputs("stream_drain", 1'b0, 32'h103, 1'b1, 2'd0, 3'd0);

    // Mid-HALF reset: entry discarded, nothing delivered afterwards
    drive(1'b0, 1'b1, 32'h20, 1'b0, 1'b0, 1'b0, '0);
    @(posedge clk);
    #1;
    check_outputs("half_fill", 1'b1, 32'h20, 1'b1, 2'd1, 3'd0);
    drive(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
    @(posedge clk);
    #1;
    check_outputs("half_reset", 1'b0, 32'h0, 1'b1, 2'd0, 3'd0);

    // Random run against the queue model
    exp_q.delete();
    last_head = '0;
    side_m    = '0;
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
    for (int c = 0; c < 10000; c++) begin
      int rdy_pct;
      rdy_pct = 20 + 20 * ((c / 2000) % 4);
      drive($urandom_range(0, 999) == 0,
            $urandom_range(0, 99) < 70,
            $urandom(),
            $urandom_range(0, 99) < rdy_pct,
            $urandom_range(0, 39) == 0,
            $urandom_range(0, 9) == 0,
            SW'($urandom_range(0, 7)));
      model_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 Parameter DATA_W, default 128, SHALL set the payload width in bits (control word, pc, addresses, ALU result, register ids, flags packed by the instantiator).
REQ-002 Parameter SIDE_W, default 3, SHALL set the width of the independently loaded side field (condition codes).
REQ-003 clk  input  1  SHALL be the only clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be synchronous and active-high.
REQ-005 in_valid  input  1  SHALL mark in_data as offered by the upstream stage.
REQ-006 in_ready  output  1  SHALL indicate the stage can accept in_data this cycle.
REQ-007 in_data  input  DATA_W  SHALL be the upstream payload.
REQ-008 out_valid  output  1  SHALL mark out_data as valid to the downstream stage.
REQ-009 out_ready  input  1  SHALL indicate downstream consumes out_data this cycle.
REQ-010 out_data  output  DATA_W  SHALL be the head payload.
REQ-011 side_load  input  1  SHALL load side_in into the side register.
REQ-012 side_in  input  SIDE_W  SHALL be the side-field value.
REQ-013 side_out  output  SIDE_W  SHALL be the side register contents.
REQ-014 flush  input  1  SHALL discard all buffered payloads (branch mispredict squash).
REQ-015 occupancy  output  2  SHALL report buffered entries (0, 1 or 2).

Function
REQ-016 Storage SHALL be a head register (drives out_data) and a skid register, each with a valid bit; states EMPTY (0 entries), HALF (head only), FULL (head+skid).
REQ-017 in_ready SHALL equal NOT skid-valid, driven from a register (no combinational path from out_ready).
REQ-018 Accept SHALL occur when in_valid AND in_ready; consume SHALL occur when out_valid AND out_ready.
REQ-019 EMPTY: accept -> in_data into head, HALF next cycle; latency in_valid to out_valid = 1 cycle.
REQ-020 HALF: accept with consume -> head loads in_data, stay HALF; accept without consume -> in_data into skid, FULL; consume without accept -> EMPTY; neither -> hold.
REQ-021 FULL: consume -> head loads skid, skid invalid, HALF; no consume -> hold; no accept possible (in_ready=0).
REQ-022 Payloads SHALL leave in strict acceptance order; no payload duplicated or dropped except by flush/reset.
REQ-023 out_data SHALL hold its last value when out_valid=0 (data registers not cleared except by reset).
REQ-024 flush SHALL clear both valid bits next cycle (EMPTY), discarding any same-cycle accept; in_ready SHALL be 1 the cycle after flush.
REQ-025 A consume in the flush cycle SHALL still count as delivered; nothing else is delivered.
REQ-026 Side register SHALL load side_in when side_load=1, independent of handshake, state and flush; otherwise hold.
REQ-027 occupancy SHALL equal 0/1/2 for EMPTY/HALF/FULL, registered.

Reset
REQ-028 reset SHALL take priority over flush, side_load and handshakes.
REQ-029 Following a reset cycle: state EMPTY, out_valid=0, in_ready=1, occupancy=0, out_data=0, skid data=0, side_out=0.
REQ-030 reset asserted mid-operation (HALF or FULL) SHALL discard all entries with no delivery after that edge.

Verification
REQ-031 Reset, then in_valid=1 data=0xA for 1 cycle, out_ready=1 -> next cycle out_valid=1 out_data=0xA, occupancy=1; following cycle occupancy=0.
REQ-032 out_ready=0, push 0x1,0x2 -> occupancy=2, in_ready=0, 0x3 held off; then out_ready=1 -> 0x1,0x2,0x3 delivered in order, one per cycle.
REQ-033 HALF with head=0x5, simultaneous accept 0x6 and consume -> 0x5 delivered, head=0x6, occupancy stays 1.
REQ-034 FULL, flush=1 with in_valid=1 data=0x9 -> next cycle occupancy=0, out_valid=0, in_ready=1; 0x9 never delivered.
REQ-035 side_load=1 side_in=3'b100 during FULL stall and during flush -> side_out=3'b100 next cycle both times; payload state unaffected.
REQ-036 Random in_valid/out_ready for 10k cycles with scoreboard -> output order equals input order, no loss, no duplication, in_ready never 1 when occupancy=2.
